// File: rtl/seq_signed_or_unsigned_mul_if.sv
// Handshake bundle for the sequential signed/unsigned multiplier: operand
// request channel (in_*) and result channel (out_*).
interface seq_signed_or_unsigned_mul_if #(
    parameter int n = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [n-1:0]   a;
    logic [n-1:0]   b;
    logic           signed_mul;
    logic           out_valid;
    logic           out_ready;
    logic [2*n-1:0] res;
    logic           res_signed;

    modport master (
        output in_valid, a, b, signed_mul, out_ready,
        input  in_ready, out_valid, res, res_signed
    );

    modport slave (
        input  in_valid, a, b, signed_mul, out_ready,
        output in_ready, out_valid, res, res_signed
    );
endinterface

// File: rtl/seq_signed_or_unsigned_mul.sv
// Iterative shift-add multiplier, one partial product per cycle. Signed mode
// sign-extends the multiplicand and subtracts the multiplier's sign-bit term.
module seq_signed_or_unsigned_mul #(
    parameter int n = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    seq_signed_or_unsigned_mul_if.slave   bus
);
    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [2*n-1:0]  acc_r;
    logic [2*n-1:0]  mcand_r;
    logic [n-1:0]    mplier_r;
    logic            sign_r;
    logic [2*n-1:0]  res_r;
    logic            res_signed_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [2*n-1:0]  step_s;

    function automatic logic [2*n-1:0] extend(input logic [n-1:0] v, input logic s);
        extend = {{n{s & v[n-1]}}, v};
    endfunction

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.res        = res_r;
    assign bus.res_signed = res_signed_r;

    // Partial-product step; the multiplier MSB carries weight -2^(n-1) in signed mode.
    always_comb begin
        step_s = acc_r;
        if (mplier_r[0]) begin
            if (sign_r && (cnt_r == CW'(n - 1))) begin
                step_s = acc_r - mcand_r;
            end else begin
                step_s = acc_r + mcand_r;
            end
        end else begin
            step_s = acc_r;
        end
    end

    // Control FSM and datapath registers; n step cycles plus one result-capture cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            acc_r        <= '0;
            mcand_r      <= '0;
            mplier_r     <= '0;
            sign_r       <= 1'b0;
            res_r        <= '0;
            res_signed_r <= 1'b0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_r    <= extend(bus.a, bus.signed_mul);
                        mplier_r   <= bus.b;
                        sign_r     <= bus.signed_mul;
                        acc_r      <= '0;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= BUSY;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_r == CW'(n)) begin
                        res_r        <= acc_r;
                        res_signed_r <= sign_r;
                        out_valid_r  <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        acc_r    <= step_s;
                        mcand_r  <= {mcand_r[2*n-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[n-1:1]};
                        cnt_r    <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_signed_or_unsigned_mul.sv
// Directed-vector bench for seq_signed_or_unsigned_mul at n=4, plus
// backpressure, mid-operation reset and a randomly throttled full sweep.
module tb_seq_signed_or_unsigned_mul;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_signed_or_unsigned_mul_if #(.n(N)) bus ();

    seq_signed_or_unsigned_mul #(.n(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        logic [7:0] r;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic issue_op(input logic [3:0] va, input logic [3:0] vb, input logic vs);
        int w;
        @(negedge clk);
        bus.a = va;
        bus.b = vb;
        bus.signed_mul = vs;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", 32'(bus.in_ready), 32'd1);
        chk("no_spurious_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = ~va;
        bus.b = ~vb;
        bus.signed_mul = ~vs;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y, input logic s);
        logic signed [7:0] sp;
        logic [7:0]        up;
        sp = $signed({{4{x[3]}}, x}) * $signed({{4{y[3]}}, y});
        up = {4'b0000, x} * {4'b0000, y};
        ref_mul = s ? sp : up;
    endfunction

    int         lat;
    int         issued;
    int         got;
    int         cyc;
    logic       pending;
    logic [8:0] idx9;
    logic [8:0] expq[$];
    logic [8:0] e;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{4'hF, 4'hF, 1'b0, 8'hE1};
        vecs[1]  = '{4'h8, 4'h8, 1'b1, 8'h40};
        vecs[2]  = '{4'h8, 4'h7, 1'b1, 8'hC8};
        vecs[3]  = '{4'hF, 4'h1, 1'b0, 8'h0F};
        vecs[4]  = '{4'hF, 4'h1, 1'b1, 8'hFF};
        vecs[5]  = '{4'h0, 4'h0, 1'b0, 8'h00};
        vecs[6]  = '{4'h0, 4'h0, 1'b1, 8'h00};
        vecs[7]  = '{4'h7, 4'h7, 1'b1, 8'h31};
        vecs[8]  = '{4'hF, 4'hF, 1'b1, 8'h01};
        vecs[9]  = '{4'h7, 4'h8, 1'b1, 8'hC8};
        vecs[10] = '{4'h8, 4'h1, 1'b1, 8'hF8};
        vecs[11] = '{4'h8, 4'h1, 1'b0, 8'h08};
        vecs[12] = '{4'h9, 4'h3, 1'b0, 8'h1B};
        vecs[13] = '{4'h9, 4'h3, 1'b1, 8'hEB};
        vecs[14] = '{4'h5, 4'h0, 1'b1, 8'h00};

        bus.in_valid = 1'b0;
        bus.a = 4'h0;
        bus.b = 4'h0;
        bus.signed_mul = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_res", 32'(bus.res), 32'd0);
        chk("reset_res_signed", 32'(bus.res_signed), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            issue_op(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_valid(lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            chk($sformatf("vec%0d_res", i), 32'(bus.res), 32'(vecs[i].r));
            chk($sformatf("vec%0d_res_signed", i), 32'(bus.res_signed), 32'(vecs[i].s));
            release_result();
        end

        // Backpressure: result must hold for 10 stalled cycles.
        issue_op(4'hF, 4'hF, 1'b0);
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'd5);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_res_hold", 32'(bus.res), 32'hE1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        release_result();
        chk("bp_res_kept", 32'(bus.res), 32'hE1);

        // Reset two cycles into an operation, then restart with 3*5.
        issue_op(4'h9, 4'h3, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_res", 32'(bus.res), 32'd0);
        @(negedge clk);
        bus.a = 4'h3;
        bus.b = 4'h5;
        bus.signed_mul = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("midrst_accept", 32'(bus.in_ready), 32'd0);
        wait_valid(lat);
        chk("midrst_latency", 32'(lat), 32'd5);
        chk("midrst_res_new", 32'(bus.res), 32'h0F);
        release_result();

        // Full sweep with random valid/ready throttling.
        issued = 0;
        got = 0;
        cyc = 0;
        pending = 1'b0;
        while (got < 512 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!pending && issued < 512 && $urandom_range(0, 3) != 0) begin
                idx9 = issued[8:0];
                bus.a = idx9[3:0];
                bus.b = idx9[7:4];
                bus.signed_mul = idx9[8];
                bus.in_valid = 1'b1;
                pending = 1'b1;
            end else if (!pending) begin
                bus.in_valid = 1'b0;
                bus.a = 4'($urandom);
                bus.b = 4'($urandom);
                bus.signed_mul = 1'($urandom);
            end else begin
                bus.in_valid = 1'b1;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back({bus.signed_mul, ref_mul(bus.a, bus.b, bus.signed_mul)});
                issued++;
                pending = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    chk("sweep_unexpected_result", 32'(bus.res), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk($sformatf("sweep%0d_res", got), 32'(bus.res), 32'(e[7:0]));
                    chk($sformatf("sweep%0d_res_signed", got), 32'(bus.res_signed), 32'(e[8]));
                end
                got++;
            end
        end
        chk("sweep_count", 32'(got), 32'd512);
        chk("sweep_issued", 32'(issued), 32'd512);
        chk("sweep_leftover", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
